// File: rtl/tdc_pulse_generator_pkg.sv
// Shared definitions for the coarse-TDC pulse generator: default field widths and FSM states.
package tdc_pulse_generator_pkg;
    localparam int TDC_CNT_W   = 16;
    localparam int TDC_WID_W   = 4;
    localparam int TDC_BURST_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } tdc_state_e;
endpackage

// File: rtl/tdc_pulse_generator_if.sv
// Control/status bundle between the pulse generator and whoever drives self-test or calibration.
interface tdc_pulse_generator_if #(
    parameter int CNT_W   = 16,
    parameter int WID_W   = 4,
    parameter int BURST_W = 8
);
    logic               go;
    logic               abort;
    logic [CNT_W-1:0]   interval;
    logic [WID_W-1:0]   width;
    logic [CNT_W-1:0]   gap;
    logic [BURST_W-1:0] burst;
    logic               start_out;
    logic               stop_out;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   exp_count;
    logic [BURST_W-1:0] pair_cnt;

    modport master (
        output go, abort, interval, width, gap, burst,
        input  start_out, stop_out, busy, done, exp_count, pair_cnt
    );

    modport slave (
        input  go, abort, interval, width, gap, burst,
        output start_out, stop_out, busy, done, exp_count, pair_cnt
    );
endinterface

// File: rtl/tdc_pulse_generator_shaper.sv
// One registered pulse: wait i_delay cycles after load, then stay high for i_width cycles.
// i_width must already be >= 1; o_last flags the final high cycle.
module tdc_pulse_generator_shaper
    import tdc_pulse_generator_pkg::*;
#(
    parameter int CNT_W = TDC_CNT_W,
    parameter int WID_W = TDC_WID_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_delay,
    input  logic [WID_W-1:0] i_width,
    output logic             o_pulse,
    output logic             o_last
);
    logic [CNT_W-1:0] r_dly;
    logic [WID_W-1:0] r_wid;
    logic             r_pulse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dly   <= '0;
            r_wid   <= '0;
            r_pulse <= 1'b0;
        end else if (i_clr) begin
            r_dly   <= '0;
            r_wid   <= '0;
            r_pulse <= 1'b0;
        end else if (i_load) begin
            // zero delay must be high on the very next cycle, so skip the delay phase
            r_dly   <= i_delay;
            r_wid   <= i_width - 1'b1;
            r_pulse <= (i_delay == '0);
        end else if (r_pulse) begin
            if (r_wid == '0) r_pulse <= 1'b0;
            else             r_wid   <= r_wid - 1'b1;
        end else if (r_dly == CNT_W'(1)) begin
            r_dly   <= '0;
            r_pulse <= 1'b1;
        end else if (r_dly != '0) begin
            r_dly   <= r_dly - 1'b1;
        end
    end

    assign o_pulse = r_pulse;
    assign o_last  = r_pulse && (r_wid == '0);
endmodule

// File: rtl/tdc_pulse_generator.sv
// Start/stop pulse-pair source for the coarse TDC: FSM, gap and burst counting, latched fields.
// Two shapers form the start (delay 0) and stop (delay interval) edges of each pair.
module tdc_pulse_generator
    import tdc_pulse_generator_pkg::*;
#(
    parameter int CNT_W   = TDC_CNT_W,
    parameter int WID_W   = TDC_WID_W,
    parameter int BURST_W = TDC_BURST_W
) (
    input logic                   clk,
    input logic                   reset,
    tdc_pulse_generator_if.slave  bus
);
    tdc_state_e         r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_interval;
    logic [WID_W-1:0]   r_width;
    logic [CNT_W-1:0]   r_gap;
    logic [BURST_W-1:0] r_burst;
    logic [CNT_W-1:0]   r_gap_cnt, w_gap_nxt;
    logic [BURST_W-1:0] r_pair_cnt, w_pair_nxt;
    logic               r_busy;
    logic               r_done;

    logic               w_launch, w_load, w_clr, w_done_nxt, w_pair_end;
    logic [WID_W-1:0]   w_width_in;
    logic [CNT_W-1:0]   w_gap_in;
    logic [BURST_W-1:0] w_burst_in;
    logic [CNT_W-1:0]   w_ld_delay;
    logic [WID_W-1:0]   w_ld_width;
    logic               w_start_pulse, w_start_last, w_stop_pulse, w_stop_last;

    // zero-valued fields mean one
    assign w_width_in = (bus.width == '0) ? WID_W'(1)   : bus.width;
    assign w_gap_in   = (bus.gap   == '0) ? CNT_W'(1)   : bus.gap;
    assign w_burst_in = (bus.burst == '0) ? BURST_W'(1) : bus.burst;

    // at launch the field registers are being written on the same edge, so bypass them
    assign w_ld_delay = w_launch ? bus.interval : r_interval;
    assign w_ld_width = w_launch ? w_width_in   : r_width;

    // a pair is finished when neither shaper will be high next cycle
    assign w_pair_end = w_stop_last && (w_start_last || !w_start_pulse);

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        w_pair_nxt  = r_pair_cnt;
        w_launch    = 1'b0;
        w_load      = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.go) begin
                    w_state_nxt = ST_PULSE;
                    w_launch    = 1'b1;
                    w_load      = 1'b1;
                    w_pair_nxt  = '0;
                end
            end
            ST_PULSE: begin
                if (w_pair_end) begin
                    w_state_nxt = ST_GAP;
                    w_gap_nxt   = r_gap - CNT_W'(1);
                    w_pair_nxt  = r_pair_cnt + BURST_W'(1);
                end
            end
            ST_GAP: begin
                if (r_gap_cnt != '0) begin
                    w_gap_nxt = r_gap_cnt - CNT_W'(1);
                end else if (r_pair_cnt == r_burst) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_PULSE;
                    w_load      = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (bus.abort) begin
            w_state_nxt = ST_IDLE;
            w_gap_nxt   = '0;
            w_pair_nxt  = r_pair_cnt;
            w_launch    = 1'b0;
            w_load      = 1'b0;
            w_clr       = 1'b1;
        end
        w_done_nxt = (w_state_nxt == ST_GAP) && (w_gap_nxt == '0) && (w_pair_nxt == r_burst);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_interval <= '0;
            r_width    <= '0;
            r_gap      <= '0;
            r_burst    <= '0;
            r_gap_cnt  <= '0;
            r_pair_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_pair_cnt <= w_pair_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= w_done_nxt;
            if (w_launch) begin
                r_interval <= bus.interval;
                r_width    <= w_width_in;
                r_gap      <= w_gap_in;
                r_burst    <= w_burst_in;
            end
        end
    end

    tdc_pulse_generator_shaper #(.CNT_W(CNT_W), .WID_W(WID_W)) u_start (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_clr),
        .i_load  (w_load),
        .i_delay ('0),
        .i_width (w_ld_width),
        .o_pulse (w_start_pulse),
        .o_last  (w_start_last)
    );

    tdc_pulse_generator_shaper #(.CNT_W(CNT_W), .WID_W(WID_W)) u_stop (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_clr),
        .i_load  (w_load),
        .i_delay (w_ld_delay),
        .i_width (w_ld_width),
        .o_pulse (w_stop_pulse),
        .o_last  (w_stop_last)
    );

    assign bus.start_out = w_start_pulse;
    assign bus.stop_out  = w_stop_pulse;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.exp_count = r_interval;
    assign bus.pair_cnt  = r_pair_cnt;
endmodule

// File: tb/tb_tdc_pulse_generator.sv
// Randomized bench for tdc_pulse_generator against a closed-form timing model of each launch.
module tb_tdc_pulse_generator;
    localparam int CNT_W   = 16;
    localparam int WID_W   = 4;
    localparam int BURST_W = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cur_t   = 0;

    tdc_pulse_generator_if #(.CNT_W(CNT_W), .WID_W(WID_W), .BURST_W(BURST_W)) bus ();

    tdc_pulse_generator #(.CNT_W(CNT_W), .WID_W(WID_W), .BURST_W(BURST_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%0d exp=%0d", tag, cur_t, got, exp);
        end
    endtask

    // pairs whose gap has begun by cycle t (launch sampled in cycle 0)
    function automatic int pairs_at(input int t, input int iv, input int w, input int g, input int b);
        int first, n;
        first = iv + w + 1;
        if (t < first) return 0;
        n = (t - first) / (iv + w + g) + 1;
        return (n > b) ? b : n;
    endfunction

    task automatic model(input int t, input int iv, input int w, input int g, input int b, input int ab,
                         output logic st, output logic sp, output logic bz, output logic dn,
                         output int pc);
        int p, endc, off;
        bit aborted;
        p       = iv + w + g;
        endc    = b * p;
        aborted = (ab >= 0) && (t > ab);
        pc = pairs_at(aborted ? ab : t, iv, w, g, b);
        st = 1'b0; sp = 1'b0; bz = 1'b0; dn = 1'b0;
        if (!aborted && t >= 1 && t <= endc) begin
            off = (t - 1) % p;
            bz  = 1'b1;
            dn  = (t == endc);
            st  = (off < w);
            sp  = (off >= iv) && (off < iv + w);
        end
    endtask

    task automatic check_all(input logic st, input logic sp, input logic bz, input logic dn,
                             input int pc, input int ec);
        chk("start_out", bus.start_out, st);
        chk("stop_out",  bus.stop_out,  sp);
        chk("busy",      bus.busy,      bz);
        chk("done",      bus.done,      dn);
        chk("pair_cnt",  bus.pair_cnt,  pc);
        chk("exp_count", bus.exp_count, ec);
    endtask

    // One launch from cycle 0; ab >= 0 raises abort in that cycle. Inputs are scrambled afterwards.
    task automatic run_launch(input int iv, input int width, input int gap, input int burst, input int ab);
        int w, g, b, endc, last;
        logic st, sp, bz, dn;
        int pc;
        bit go_ok;
        w    = (width == 0) ? 1 : width;
        g    = (gap   == 0) ? 1 : gap;
        b    = (burst == 0) ? 1 : burst;
        endc = b * (iv + w + g);
        last = (ab >= 0) ? ab + 3 : endc + 3;
        @(posedge clk); #1;
        bus.go       = 1'b1;
        bus.abort    = 1'b0;
        bus.interval = CNT_W'(iv);
        bus.width    = WID_W'(width);
        bus.gap      = CNT_W'(gap);
        bus.burst    = BURST_W'(burst);
        for (int t = 1; t <= last; t++) begin
            @(posedge clk); #1;
            go_ok        = (t <= endc) && (ab < 0 || t <= ab);
            bus.go       = go_ok && ((t == 10) || ($urandom_range(0, 3) == 0));
            bus.abort    = (t == ab);
            bus.interval = CNT_W'($urandom);
            bus.width    = WID_W'($urandom);
            bus.gap      = CNT_W'($urandom);
            bus.burst    = BURST_W'($urandom);
            @(negedge clk);
            cur_t = t;
            model(t, iv, w, g, b, ab, st, sp, bz, dn, pc);
            check_all(st, sp, bz, dn, pc, iv);
        end
        bus.go    = 1'b0;
        bus.abort = 1'b0;
    endtask

    initial begin
        int iv, wd, gp, bu, ab, endc;
        reset        = 1'b1;
        bus.go       = 1'b0;
        bus.abort    = 1'b0;
        bus.interval = '0;
        bus.width    = '0;
        bus.gap      = '0;
        bus.burst    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        reset = 1'b0;

        run_launch(5, 1, 2, 1, -1);
        run_launch(0, 2, 2, 1, -1);
        run_launch(5, 1, 2, 3, -1);

        // go together with abort in IDLE: no launch, previous status held
        @(posedge clk); #1;
        bus.go = 1'b1; bus.abort = 1'b1; bus.interval = CNT_W'(9);
        @(posedge clk); #1;
        bus.go = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        cur_t = -1;
        check_all(1'b0, 1'b0, 1'b0, 1'b0, 3, 5);

        run_launch(5, 1, 2, 1, 4);
        run_launch(5, 1, 2, 1, -1);

        // asynchronous reset in the middle of the stop pulse
        @(posedge clk); #1;
        bus.go = 1'b1; bus.interval = CNT_W'(5); bus.width = WID_W'(1);
        bus.gap = CNT_W'(2); bus.burst = BURST_W'(1);
        for (int t = 1; t <= 6; t++) begin
            @(posedge clk); #1;
            bus.go = 1'b0;
        end
        @(negedge clk);
        cur_t = 6;
        chk("pre_reset_stop", bus.stop_out, 1'b1);
        #1 reset = 1'b1;
        #1;
        check_all(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_all(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_launch(5, 1, 2, 1, -1);

        for (int n = 0; n < 15; n++) begin
            iv   = $urandom_range(0, 30);
            wd   = $urandom_range(0, 15);
            gp   = $urandom_range(0, 8);
            bu   = $urandom_range(0, 4);
            endc = ((bu == 0) ? 1 : bu) * (iv + ((wd == 0) ? 1 : wd) + ((gp == 0) ? 1 : gp));
            ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, endc - 1) : -1;
            run_launch(iv, wd, gp, bu, ab);
        end

        run_launch(65535, 0, 0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
